// File: rtl/if_id_skid_pkg.sv
// Constants shared by the IF->ID pipeline register and its slot sub-module.
package if_id_skid_pkg;
  localparam logic              RST_ENABLE    = 1'b1;
  localparam int                INST_ADDR_BUS = 32;
  localparam int                INST_BUS      = 32;
  localparam logic [31:0]       ZERO_WORD     = 32'h0;
  localparam logic [INST_BUS-1:0] NOP_INST_WORD = '0;

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/if_id_skid_pipe_slot.sv
// One pipeline slot: valid bit plus payload register with load / clear / hold.
module if_id_skid_pipe_slot
  import if_id_skid_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_clr,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  // Clear wins over load so a flush kills a word arriving in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst == RST_ENABLE) begin
      r_valid <= 1'b0;
      r_data  <= W'(ZERO_WORD);
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/if_id_skid.sv
// IF->ID pipeline register with valid/ready handshake, flush and optional skid slot.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS,
  parameter int                INST_W   = INST_BUS,
  parameter bit                SKID     = 1'b1,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_WORD)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_if_valid,
  output logic              o_if_ready,
  input  logic [ADDR_W-1:0] i_if_pc,
  input  logic [INST_W-1:0] i_if_inst,
  output logic              o_id_valid,
  input  logic              i_id_ready,
  output logic [ADDR_W-1:0] o_id_pc,
  output logic [INST_W-1:0] o_id_inst,
  output logic [1:0]        o_occupancy
);
  localparam int PW = ADDR_W + INST_W;

  logic          w_in_fire, w_out_fire;
  logic          w_main_valid, w_main_load, w_main_clr;
  logic          w_skid_valid, w_skid_load, w_skid_pop, w_skid_next;
  logic [PW-1:0] w_in_data, w_main_din, w_main_data, w_skid_data;
  logic          r_live, r_ready;

  assign w_in_data  = {i_if_pc, i_if_inst};
  assign w_in_fire  = i_if_valid & o_if_ready;
  assign w_out_fire = w_main_valid & i_id_ready;

  // Skid refills main first; a new word only lands in skid when main is stuck.
  always_comb begin
    w_main_load = 1'b0;
    w_main_din  = w_in_data;
    w_skid_load = 1'b0;
    w_skid_pop  = 1'b0;
    if (w_out_fire && w_skid_valid) begin
      w_main_load = 1'b1;
      w_main_din  = w_skid_data;
      w_skid_pop  = 1'b1;
    end else if (w_in_fire && (!w_main_valid || w_out_fire)) begin
      w_main_load = 1'b1;
    end else if (w_in_fire) begin
      w_skid_load = 1'b1;
    end
  end

  assign w_main_clr  = i_flush | (w_out_fire & ~w_main_load);
  assign w_skid_next = ~i_flush & (w_skid_load | (w_skid_valid & ~w_skid_pop));

  // r_live holds if_ready low for the first cycle after reset is released.
  always_ff @(posedge i_clk) begin
    if (i_rst == RST_ENABLE) begin
      r_live  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_ready <= ~w_skid_next;
    end
  end

  if_id_skid_pipe_slot #(.W(PW)) u_main (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_main_load),
    .i_clr   (w_main_clr),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  generate
    if (SKID) begin : g_skid
      if_id_skid_pipe_slot #(.W(PW)) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_skid_load),
        .i_clr   (i_flush | w_skid_pop),
        .i_data  (w_in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
      );
      assign o_if_ready = r_ready;
    end else begin : g_noskid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
      assign o_if_ready   = r_live & (~w_main_valid | i_id_ready);
    end
  endgenerate

  assign o_id_valid  = w_main_valid;
  assign o_id_pc     = w_main_data[PW-1:INST_W];
  assign o_id_inst   = w_main_valid ? w_main_data[INST_W-1:0] : NOP_INST;
  assign o_occupancy = occ_count(w_main_valid, w_skid_valid);
endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: SKID=1 and SKID=0 instances checked against FIFO models.
module tb_if_id_skid;
  logic        clk = 1'b0;
  logic        rst, flush, if_valid, id_ready;
  logic [31:0] if_pc, if_inst;
  logic        r1, v1, r0, v0;
  logic [31:0] pc1, inst1, pc0, inst0;
  logic [1:0]  occ1, occ0;
  int          errs = 0, checks = 0;
  logic [63:0] q1[$], q0[$];
  bit          live = 1'b0;

  always #5 clk = ~clk;

  if_id_skid #(.SKID(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_if_valid(if_valid), .o_if_ready(r1),
    .i_if_pc(if_pc), .i_if_inst(if_inst), .o_id_valid(v1), .i_id_ready(id_ready),
    .o_id_pc(pc1), .o_id_inst(inst1), .o_occupancy(occ1));

  if_id_skid #(.SKID(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_if_valid(if_valid), .o_if_ready(r0),
    .i_if_pc(if_pc), .i_if_inst(if_inst), .o_id_valid(v0), .i_id_ready(id_ready),
    .o_id_pc(pc0), .o_id_inst(inst0), .o_occupancy(occ0));

  // Reference: a FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
  function automatic bit exp_rdy1();
    return live && (q1.size() < 2);
  endfunction
  function automatic bit exp_rdy0();
    return live && (q0.size() == 0 || id_ready);
  endfunction

  task automatic tick();
    bit in1, in0, out1, out0;
    in1  = if_valid && exp_rdy1();
    in0  = if_valid && exp_rdy0();
    out1 = (q1.size() > 0) && id_ready;
    out0 = (q0.size() > 0) && id_ready;
    @(posedge clk);
    if (rst) begin
      q1.delete(); q0.delete(); live = 1'b0;
    end else begin
      live = 1'b1;
      if (flush) begin
        q1.delete(); q0.delete();
      end else begin
        if (out1) void'(q1.pop_front());
        if (in1)  q1.push_back({if_pc, if_inst});
        if (out0) void'(q0.pop_front());
        if (in0)  q0.push_back({if_pc, if_inst});
      end
    end
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc);
    if_valid = 1'b1; if_pc = pc; if_inst = pc ^ 32'hA5A5_0000;
    tick();
    if_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; if_valid = 1'b1; id_ready = 1'b0;
    if_pc = 32'h100; if_inst = 32'hDEAD_BEEF;
    @(negedge clk);
    tick(); tick();
    #1;
    checks++; if (v1 !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", v1); end
    checks++; if (inst1 !== 32'h0) begin errs++; $display("FAIL rst_inst got=%h exp=0", inst1); end
    checks++; if (pc1 !== 32'h0) begin errs++; $display("FAIL rst_pc got=%h exp=0", pc1); end
    checks++; if (occ1 !== 2'd0) begin errs++; $display("FAIL rst_occ got=%0d exp=0", occ1); end
    checks++; if (r1 !== 1'b0 || r0 !== 1'b0) begin errs++; $display("FAIL rst_ready got=%b%b exp=00", r1, r0); end
    rst = 1'b0; if_valid = 1'b0;
    tick();
    #1;
    checks++; if (r1 !== 1'b1 || r0 !== 1'b1) begin errs++; $display("FAIL rst_ready_after got=%b%b exp=11", r1, r0); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
    id_ready = 1'b1; if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_pc = pcs[i]; if_inst = pcs[i] ^ 32'hA5A5_0000;
      tick(); #1;
      checks++; if (v1 !== 1'b1 || pc1 !== pcs[i]) begin errs++; $display("FAIL stream_pc%0d got=%b/%h exp=1/%h", i, v1, pc1, pcs[i]); end
      checks++; if (occ1 !== 2'd1) begin errs++; $display("FAIL stream_occ%0d got=%0d exp=1", i, occ1); end
      checks++; if (v0 !== 1'b1 || pc0 !== pcs[i]) begin errs++; $display("FAIL stream0_pc%0d got=%b/%h exp=1/%h", i, v0, pc0, pcs[i]); end
    end
    if_valid = 1'b0;
    tick(); #1;
    checks++; if (occ1 !== 2'd0 || inst1 !== 32'h0) begin errs++; $display("FAIL stream_drain got=%0d/%h exp=0/0", occ1, inst1); end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    push(32'h10); push(32'h14); #1;
    checks++; if (occ1 !== 2'd2) begin errs++; $display("FAIL bp_occ got=%0d exp=2", occ1); end
    checks++; if (r1 !== 1'b0) begin errs++; $display("FAIL bp_ready got=%b exp=0", r1); end
    push(32'h99); #1;
    checks++; if (pc1 !== 32'h10 || inst1 !== (32'h10 ^ 32'hA5A5_0000)) begin errs++; $display("FAIL bp_hold got=%h/%h exp=10", pc1, inst1); end
    id_ready = 1'b1;
    tick(); #1;
    checks++; if (v1 !== 1'b1 || pc1 !== 32'h14) begin errs++; $display("FAIL bp_second got=%b/%h exp=1/14", v1, pc1); end
    checks++; if (r1 !== 1'b1) begin errs++; $display("FAIL bp_ready_back got=%b exp=1", r1); end
    tick(); #1;
    checks++; if (occ1 !== 2'd0) begin errs++; $display("FAIL bp_empty got=%0d exp=0", occ1); end
  endtask

  task automatic test_flush();
    id_ready = 1'b0;
    push(32'h20); push(32'h24);
    flush = 1'b1; if_valid = 1'b1; if_pc = 32'h18; if_inst = 32'h18;
    tick();
    flush = 1'b0; if_valid = 1'b0; #1;
    checks++; if (v1 !== 1'b0 || occ1 !== 2'd0) begin errs++; $display("FAIL flush_full got=%b/%0d exp=0/0", v1, occ1); end
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++; if (v1 !== 1'b0) begin errs++; $display("FAIL flush_ghost%0d got=%b/%h exp=0", i, v1, pc1); end
    end
    id_ready = 1'b0;
    push(32'h28);
    flush = 1'b1; if_valid = 1'b1; if_pc = 32'h2C; if_inst = 32'h2C; #1;
    checks++; if (r1 !== 1'b1) begin errs++; $display("FAIL flush_ready got=%b exp=1", r1); end
    tick();
    flush = 1'b0; if_valid = 1'b0; #1;
    checks++; if (v1 !== 1'b0 || occ1 !== 2'd0) begin errs++; $display("FAIL flush_discard got=%b/%0d exp=0/0", v1, occ1); end
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0;
    push(32'h30); push(32'h34);
    rst = 1'b1; if_valid = 1'b1; if_pc = 32'h38;
    tick();
    rst = 1'b0; if_valid = 1'b0; #1;
    checks++; if (occ1 !== 2'd0 || v1 !== 1'b0) begin errs++; $display("FAIL rmid_drop got=%0d/%b exp=0/0", occ1, v1); end
    tick();
    push(32'h40); #1;
    checks++; if (v1 !== 1'b1 || pc1 !== 32'h40) begin errs++; $display("FAIL rmid_first got=%b/%h exp=1/40", v1, pc1); end
    checks++; if (v0 !== 1'b1 || pc0 !== 32'h40) begin errs++; $display("FAIL rmid_first0 got=%b/%h exp=1/40", v0, pc0); end
  endtask

  task automatic test_skid0();
    id_ready = 1'b1; tick();
    id_ready = 1'b0;
    push(32'h50);
    if_valid = 1'b1; if_pc = 32'h54; if_inst = 32'h54 ^ 32'hA5A5_0000; #1;
    checks++; if (r0 !== 1'b0) begin errs++; $display("FAIL s0_block got=%b exp=0", r0); end
    id_ready = 1'b1; #1;
    checks++; if (r0 !== 1'b1) begin errs++; $display("FAIL s0_ready got=%b exp=1", r0); end
    tick(); #1;
    checks++; if (v0 !== 1'b1 || pc0 !== 32'h54 || occ0 !== 2'd1) begin errs++; $display("FAIL s0_replace got=%b/%h/%0d exp=1/54/1", v0, pc0, occ0); end
    if_valid = 1'b0; tick();
  endtask

  task automatic test_random();
    logic [63:0] h1, h0;
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 2) != 0);
      if_pc    = $urandom & 32'hFFFF_FFFC;
      if_inst  = $urandom;
      #1;
      h1 = (q1.size() > 0) ? q1[0] : 64'h0;
      h0 = (q0.size() > 0) ? q0[0] : 64'h0;
      checks++; if (occ1 !== 2'(q1.size()) || v1 !== (q1.size() > 0)) begin errs++; $display("FAIL rnd1_occ c=%0d got=%0d exp=%0d", c, occ1, q1.size()); end
      checks++; if (r1 !== exp_rdy1()) begin errs++; $display("FAIL rnd1_ready c=%0d got=%b exp=%b", c, r1, exp_rdy1()); end
      checks++; if (inst1 !== h1[31:0] || (q1.size() > 0 && pc1 !== h1[63:32])) begin errs++; $display("FAIL rnd1_data c=%0d got=%h/%h exp=%h", c, pc1, inst1, h1); end
      checks++; if (occ0 !== 2'(q0.size()) || v0 !== (q0.size() > 0)) begin errs++; $display("FAIL rnd0_occ c=%0d got=%0d exp=%0d", c, occ0, q0.size()); end
      checks++; if (r0 !== exp_rdy0()) begin errs++; $display("FAIL rnd0_ready c=%0d got=%b exp=%b", c, r0, exp_rdy0()); end
      checks++; if (inst0 !== h0[31:0] || (q0.size() > 0 && pc0 !== h0[63:32])) begin errs++; $display("FAIL rnd0_data c=%0d got=%h/%h exp=%h", c, pc0, inst0, h0); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_skid0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
